chip_sequencer: RTL and testbench
=================================

Name: chip_sequencer

Overview:
Instruction sequencer for the 16-register/ALU datapath (CHIP). It fetches 16-bit opcodes from an external instruction memory using a req/valid handshake. Each opcode is held stable on OPCODE through two phases: decode/read, then operate/write. R_ENABLE_WRITE is pulsed in the write phase only. The block replaces the free-running one-bit counter as the source of OPCODE and R_ENABLE_WRITE, and adds a program counter, a halt instruction and write protection for the fixed registers.

Parameters:
PC_WIDTH, 8, instruction address width; PC wraps modulo 2^PC_WIDTH
OPCODE_WIDTH, 16, opcode width; field positions fixed as in CHIP
HALT_CODE, 4'hF, ALU field value (OPCODE[3:0]) decoded as HALT
FIXED_REG_LIMIT, 4, destination addresses below this are read-only (F0..F3)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous reset, active low
START  input  1  level; starts or restarts execution at PC=0 (sampled in IDLE/HALTED only)
IMEM_REQ  output  1  fetch request, high for every cycle in FETCH
IMEM_ADDR  output  PC_WIDTH  fetch address, equals PC
IMEM_VALID  input  1  IMEM_DATA valid this cycle
IMEM_DATA  input  OPCODE_WIDTH  fetched opcode
OPCODE  output  OPCODE_WIDTH  registered opcode to CHIP datapath
R_ENABLE_WRITE  output  1  register-file write enable to CHIP demux
WRITE_BLOCKED  output  1  one-cycle pulse: write to fixed register suppressed
BUSY  output  1  high in FETCH/DECODE/WRITE
HALTED  output  1  high in HALT state
RETIRED  output  16  count of completed (WRITE-phase) instructions, wraps

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE; PC=0; OPCODE=0; RETIRED=0.
  - IMEM_REQ, R_ENABLE_WRITE, WRITE_BLOCKED, BUSY and HALTED are all 0.
  - Reset mid-instruction aborts it: no write, no PC increment.
- State is one-hot or binary, held in a registered state register.
- All outputs are decoded from registered state/OPCODE only; no combinational path from any input to any output.
- IDLE:
  - START=1 -> FETCH, PC=0, RETIRED=0.
  - Otherwise stay.
- FETCH:
  - IMEM_REQ=1, IMEM_ADDR=PC.
  - On IMEM_VALID=1: OPCODE<=IMEM_DATA, -> DECODE.
  - Otherwise hold. The wait is unbounded, and OPCODE keeps its previous value while waiting.
- DECODE:
  - Exactly one cycle; OPCODE stable so the CHIP read muxes and ALU settle.
  - R_ENABLE_WRITE=0.
  - If OPCODE[3:0]==HALT_CODE -> HALT. A halt performs no write and does not increment PC or RETIRED.
  - Else -> WRITE.
- WRITE:
  - Exactly one cycle.
  - If OPCODE[15:12] >= FIXED_REG_LIMIT: R_ENABLE_WRITE=1.
  - Else: R_ENABLE_WRITE=0 and WRITE_BLOCKED=1.
  - At the end of the cycle: PC<=PC+1 (PC=2^PC_WIDTH-1 wraps to 0), RETIRED<=RETIRED+1 (wraps), -> FETCH.
- HALT:
  - HALTED=1, BUSY=0, OPCODE held.
  - START=1 -> FETCH with PC=0 and RETIRED=0.
- Latency:
  - Minimum 3 cycles per instruction (FETCH with immediate VALID, DECODE, WRITE).
  - R_ENABLE_WRITE is high for exactly one cycle per retired instruction, 2 cycles after the accepted VALID.
- Ignored inputs:
  - IMEM_VALID outside FETCH is ignored and IMEM_DATA is not captured.
  - START outside IDLE/HALT is ignored.
  - START held high continuously in HALT restarts immediately (one HALT cycle).

Decomposition:
- Shared package chip_pkg contains:
  - state encoding enum (IDLE, FETCH, DECODE, WRITE, HALT)
  - HALT_CODE and FIXED_REG_LIMIT constants
  - OPCODE field position constants: ALU [3:0], SRC0 [7:4], SRC1 [11:8], DST [15:12]
- One natural sub-module, program_counter:
  - PC_WIDTH register with async active-low reset, synchronous clear and increment enable.
  - Reused for RETIRED with width 16.

Test Plan:
- Reset then START=1, memory returns VALID on the first FETCH cycle with opcode 16'h4120 at addr 0 -> IMEM_REQ high 1 cycle, OPCODE=16'h4120 next cycle, R_ENABLE_WRITE=1 exactly 2 cycles after VALID, PC=1, RETIRED=1.
- VALID delayed 5 cycles at addr 1 -> IMEM_REQ high 6 cycles, IMEM_ADDR=1 throughout, no R_ENABLE_WRITE pulse until 2 cycles after VALID.
- Opcode 16'h2120 (DST=2, fixed) -> R_ENABLE_WRITE stays 0, WRITE_BLOCKED pulses 1 cycle, PC still increments.
- Opcode 16'h000F -> HALTED=1 after DECODE, no write, PC and RETIRED unchanged; START pulse -> FETCH at addr 0, RETIRED=0.
- PC preloaded to 255 via 255 sequential non-halt opcodes -> after the 256th WRITE, PC=0 and IMEM_ADDR=0.
- RST_N asserted during WRITE with R_ENABLE_WRITE=1 -> all outputs 0 immediately (asynchronous), state IDLE, no PC increment recorded.

Source files
------------

// File: rtl/chip_pkg.sv
// Shared definitions for the CHIP instruction sequencer: state encoding,
// decode constants and opcode field positions.
package chip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WRITE,
    ST_HALT
  } state_t;

  localparam logic [3:0] HALT_CODE       = 4'hF;
  localparam logic [3:0] FIXED_REG_LIMIT = 4'd4;

  localparam int ALU_LSB  = 0;
  localparam int ALU_MSB  = 3;
  localparam int SRC0_LSB = 4;
  localparam int SRC0_MSB = 7;
  localparam int SRC1_LSB = 8;
  localparam int SRC1_MSB = 11;
  localparam int DST_LSB  = 12;
  localparam int DST_MSB  = 15;

endpackage

// File: rtl/chip_sequencer_program_counter.sv
// Wrapping up-counter with synchronous clear and increment enable; used for
// both the program counter and the retired-instruction count.
module program_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/chip_sequencer.sv
// Fetch/decode/write sequencer for the CHIP datapath: fetches opcodes over a
// req/valid handshake, holds each for a decode and a write phase.
module chip_sequencer
  import chip_pkg::*;
#(
  parameter int PC_WIDTH     = 8,
  parameter int OPCODE_WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    START,
  output logic                    IMEM_REQ,
  output logic [PC_WIDTH-1:0]     IMEM_ADDR,
  input  logic                    IMEM_VALID,
  input  logic [OPCODE_WIDTH-1:0] IMEM_DATA,
  output logic [OPCODE_WIDTH-1:0] OPCODE,
  output logic                    R_ENABLE_WRITE,
  output logic                    WRITE_BLOCKED,
  output logic                    BUSY,
  output logic                    HALTED,
  output logic [15:0]             RETIRED
);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic [PC_WIDTH-1:0]     w_pc;
  logic [15:0]             w_retired;
  logic                    w_start_ok;
  logic                    w_retire;
  logic                    w_dst_writable;

  assign w_start_ok     = START && ((r_state == ST_IDLE) || (r_state == ST_HALT));
  assign w_retire       = (r_state == ST_WRITE);
  assign w_dst_writable = (r_opcode[DST_MSB:DST_LSB] >= FIXED_REG_LIMIT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture only while fetching; stray VALIDs elsewhere leave OPCODE untouched.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_opcode <= '0;
    end else if ((r_state == ST_FETCH) && IMEM_VALID) begin
      r_opcode <= IMEM_DATA;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (START) w_next_state = ST_FETCH;
      ST_FETCH:  if (IMEM_VALID) w_next_state = ST_DECODE;
      ST_DECODE: w_next_state = (r_opcode[ALU_MSB:ALU_LSB] == HALT_CODE) ? ST_HALT : ST_WRITE;
      ST_WRITE:  w_next_state = ST_FETCH;
      ST_HALT:   if (START) w_next_state = ST_FETCH;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    IMEM_REQ       = 1'b0;
    R_ENABLE_WRITE = 1'b0;
    WRITE_BLOCKED  = 1'b0;
    BUSY           = 1'b0;
    HALTED         = 1'b0;
    case (r_state)
      ST_FETCH: begin
        IMEM_REQ = 1'b1;
        BUSY     = 1'b1;
      end
      ST_DECODE: BUSY = 1'b1;
      ST_WRITE: begin
        BUSY           = 1'b1;
        R_ENABLE_WRITE = w_dst_writable;
        WRITE_BLOCKED  = !w_dst_writable;
      end
      ST_HALT: HALTED = 1'b1;
      default: ;
    endcase
  end

  program_counter #(.WIDTH(PC_WIDTH)) u_pc (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clear (w_start_ok),
    .i_inc   (w_retire),
    .o_count (w_pc)
  );

  program_counter #(.WIDTH(16)) u_retired (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clear (w_start_ok),
    .i_inc   (w_retire),
    .o_count (w_retired)
  );

  assign IMEM_ADDR = w_pc;
  assign OPCODE    = r_opcode;
  assign RETIRED   = w_retired;

endmodule

// File: tb/tb_chip_sequencer.sv
// Scoreboard bench for chip_sequencer: directed programs, a latency-controlled
// instruction memory responder, and a monitor checking every write/halt event.
module tb_chip_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        IMEM_REQ;
  logic [7:0]  IMEM_ADDR;
  logic        IMEM_VALID = 1'b0;
  logic [15:0] IMEM_DATA = 16'h0;
  logic [15:0] OPCODE;
  logic        R_ENABLE_WRITE;
  logic        WRITE_BLOCKED;
  logic        BUSY;
  logic        HALTED;
  logic [15:0] RETIRED;

  chip_sequencer #(.PC_WIDTH(8), .OPCODE_WIDTH(16)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .START          (START),
    .IMEM_REQ       (IMEM_REQ),
    .IMEM_ADDR      (IMEM_ADDR),
    .IMEM_VALID     (IMEM_VALID),
    .IMEM_DATA      (IMEM_DATA),
    .OPCODE         (OPCODE),
    .R_ENABLE_WRITE (R_ENABLE_WRITE),
    .WRITE_BLOCKED  (WRITE_BLOCKED),
    .BUSY           (BUSY),
    .HALTED         (HALTED),
    .RETIRED        (RETIRED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          halt;
    bit          we;
    bit          blk;
    logic [15:0] op;
    logic [7:0]  pc;
    logic [15:0] ret;
    int          req_len;   // -1: don't care
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem[256];
  int          lat_mem[256];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit halt, input bit we, input bit blk, input logic [15:0] op,
                      input logic [7:0] pc, input logic [15:0] ret, input int req_len);
    exp_t e;
    e.halt = halt; e.we = we; e.blk = blk; e.op = op;
    e.pc = pc; e.ret = ret; e.req_len = req_len;
    sb.push_back(e);
  endtask

  // Memory responder: VALID after lat_mem[addr] waiting cycles; junk VALID outside FETCH.
  int wait_cnt = 0;
  always @(negedge CLK) begin
    if (IMEM_REQ) begin
      if (wait_cnt >= lat_mem[IMEM_ADDR]) begin
        IMEM_VALID = 1'b1;
        IMEM_DATA  = mem[IMEM_ADDR];
        wait_cnt   = 0;
      end else begin
        IMEM_VALID = 1'b0;
        IMEM_DATA  = 16'hDEAD;
        wait_cnt++;
      end
    end else begin
      IMEM_VALID = 1'b1;
      IMEM_DATA  = 16'hBEEF;
      wait_cnt   = 0;
    end
  end

  // Monitor: pops one expectation per write-phase cycle or HALT entry.
  int   cyc = 0;
  int   req_run = 0;
  int   acc_cyc = -100;
  int   acc_len = 0;
  bit   prev_halted = 1'b0;
  exp_t mon_e;
  always @(negedge CLK) begin
    #1;
    cyc++;
    if (IMEM_REQ) begin
      req_run++;
      if (IMEM_VALID) begin
        acc_cyc = cyc;
        acc_len = req_run;
        req_run = 0;
      end
    end else begin
      req_run = 0;
    end
    if (R_ENABLE_WRITE || WRITE_BLOCKED || (HALTED && !prev_halted)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: we=%0b blocked=%0b halted=%0b with empty scoreboard",
                 R_ENABLE_WRITE, WRITE_BLOCKED, HALTED);
      end else begin
        mon_e = sb.pop_front();
        check("ev_halted",  32'(HALTED),         32'(mon_e.halt));
        check("ev_write",   32'(R_ENABLE_WRITE), 32'(mon_e.we));
        check("ev_blocked", 32'(WRITE_BLOCKED),  32'(mon_e.blk));
        check("ev_opcode",  32'(OPCODE),         32'(mon_e.op));
        check("ev_pc",      32'(IMEM_ADDR),      32'(mon_e.pc));
        check("ev_retired", 32'(RETIRED),        32'(mon_e.ret));
        check("ev_valid_to_event_cycles", 32'(cyc - acc_cyc), 32'd2);
        if (mon_e.req_len >= 0) check("ev_req_cycles", 32'(acc_len), 32'(mon_e.req_len));
      end
    end
    prev_halted = HALTED;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},     32'(IMEM_REQ),       32'd0);
    check({tag, "_we"},      32'(R_ENABLE_WRITE), 32'd0);
    check({tag, "_blocked"}, 32'(WRITE_BLOCKED),  32'd0);
    check({tag, "_busy"},    32'(BUSY),           32'd0);
    check({tag, "_halted"},  32'(HALTED),         32'd0);
    check({tag, "_opcode"},  32'(OPCODE),         32'd0);
    check({tag, "_pc"},      32'(IMEM_ADDR),      32'd0);
    check({tag, "_retired"}, 32'(RETIRED),        32'd0);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [7:0] a;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h7000;
      lat_mem[i] = 0;
    end
    mem[0] = 16'h4120;
    mem[1] = 16'h5321; lat_mem[1] = 5;
    mem[2] = 16'h2120;
    mem[3] = 16'h000F;

    // Reset state
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    check("idle_no_start_busy", 32'(BUSY), 32'd0);
    check("idle_no_start_req",  32'(IMEM_REQ), 32'd0);

    // Program: writable, delayed fetch, fixed-register write, halt
    push(0, 1, 0, 16'h4120, 8'd0, 16'd0, 1);
    push(0, 1, 0, 16'h5321, 8'd1, 16'd1, 6);
    push(0, 0, 1, 16'h2120, 8'd2, 16'd2, 1);
    push(1, 0, 0, 16'h000F, 8'd3, 16'd3, 1);
    pulse_start();
    check("start_req",  32'(IMEM_REQ),  32'd1);
    check("start_addr", 32'(IMEM_ADDR), 32'd0);
    check("start_busy", 32'(BUSY),      32'd1);

    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge CLK);
      #1;
      if (HALTED) ok = 1'b1;
    end
    check("halt_reached", 32'(ok), 32'd1);
    repeat (2) @(negedge CLK);
    #1;
    check("halt_stays_halted", 32'(HALTED),         32'd1);
    check("halt_busy",         32'(BUSY),           32'd0);
    check("halt_pc",           32'(IMEM_ADDR),      32'd3);
    check("halt_retired",      32'(RETIRED),        32'd3);
    check("halt_opcode",       32'(OPCODE),         32'h000F);
    check("halt_no_write",     32'(R_ENABLE_WRITE), 32'd0);

    // Restart from HALT and run 256 writes so the PC wraps
    for (int i = 0; i < 256; i++) begin
      a = i[7:0];
      mem[i] = {4'h7, a, 4'h0};
      lat_mem[i] = 0;
      push(0, 1, 0, {4'h7, a, 4'h0}, a, 16'(i), 1);
    end
    pulse_start();
    check("restart_halted",  32'(HALTED),    32'd0);
    check("restart_req",     32'(IMEM_REQ),  32'd1);
    check("restart_addr",    32'(IMEM_ADDR), 32'd0);
    check("restart_retired", 32'(RETIRED),   32'd0);

    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      #1;
      if (sb.size() <= 255) ok = 1'b1;
    end
    check("wrap_first_write_seen", 32'(ok), 32'd1);
    lat_mem[0] = 1000000;   // stall the post-wrap fetch at address 0

    ok = 1'b0;
    for (int i = 0; i < 1200 && !ok; i++) begin
      @(negedge CLK);
      #1;
      if (sb.size() == 0) ok = 1'b1;
    end
    check("wrap_all_writes_seen", 32'(ok), 32'd1);
    repeat (2) @(negedge CLK);
    #1;
    check("wrap_req",     32'(IMEM_REQ),  32'd1);
    check("wrap_addr",    32'(IMEM_ADDR), 32'd0);
    check("wrap_retired", 32'(RETIRED),   32'd256);

    // Reset asserted asynchronously during a write phase
    push(0, 1, 0, 16'h7000, 8'd0, 16'd256, -1);
    lat_mem[0] = 0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      #1;
      if (R_ENABLE_WRITE) ok = 1'b1;
    end
    check("rst_write_seen", 32'(ok), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check_all_zero("midwrite_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("post_reset_idle_busy", 32'(BUSY),      32'd0);
    check("post_reset_idle_req",  32'(IMEM_REQ),  32'd0);
    check("post_reset_pc",        32'(IMEM_ADDR), 32'd0);
    check("scoreboard_drained",   32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
